// File: rtl/io_bus_master.sv
// io_bus_master: queued initiator for the 64-bit CPU-side IO bus.
// Requests are buffered in a small FIFO, issued one at a time onto the bus,
// and each produces exactly one response (data or error) in request order.
//
// Handshakes: req_valid/req_ready and resp_valid/resp_ready are strict
// valid/ready pairs. A transfer happens at a posedge where both are high.
// A valid, once raised by this block, is held with stable payload until it
// is accepted. On the bus side, mem_addr_valid starts a transaction and
// mem_din_ready completes it at the posedge where it is sampled high.
module io_bus_master #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [63:0]                   req_addr,
  input  logic [63:0]                   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [63:0]                   resp_rdata,
  output logic                          resp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [63:0]                   mem_addr,
  output logic [63:0]                   mem_dout,
  output logic                          mem_dout_write,
  output logic                          mem_addr_valid,
  input  logic [63:0]                   mem_din,
  input  logic                          mem_din_ready,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  state_t        state;
  logic [15:0]   tmo_cnt;

  req_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;
  req_t          head;
  req_t          in_entry;

  // Queue handshake and pop decision; pops only happen from IDLE so a
  // freshly pushed request is never bypassed straight onto the bus.
  always_comb begin
    req_ready  = (count != LW'(FIFO_DEPTH));
    push       = req_valid && req_ready;
    pop        = (state == ST_IDLE) && (count != '0);
    head       = fifo_mem[rd_ptr];
    in_entry   = '{write: req_write, addr: req_addr, wdata: req_wdata};
    fifo_level = count;
    busy       = (state != ST_IDLE) || (count != '0);
    state_dbg  = state;
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_entry;
    end
  end

  // Queue pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      mem_addr       <= '0;
      mem_dout       <= '0;
      mem_dout_write <= 1'b0;
      mem_addr_valid <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            if (head.addr[2:0] != 3'b000) begin
              // Misaligned: answer with an error, never touch the bus.
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              mem_addr       <= head.addr;
              mem_dout       <= head.write ? head.wdata : 64'd0;
              mem_dout_write <= head.write;
              mem_addr_valid <= 1'b1;
              tmo_cnt        <= '0;
              state          <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (mem_din_ready) begin
            // Ready wins over a coinciding timeout.
            resp_rdata     <= mem_dout_write ? 64'd0 : mem_din;
            resp_err       <= 1'b0;
            resp_valid     <= 1'b1;
            mem_addr       <= '0;
            mem_dout       <= '0;
            mem_dout_write <= 1'b0;
            mem_addr_valid <= 1'b0;
            state          <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TIMEOUT - 16'd1) begin
              resp_rdata     <= '0;
              resp_err       <= 1'b1;
              resp_valid     <= 1'b1;
              mem_addr       <= '0;
              mem_dout       <= '0;
              mem_dout_write <= 1'b0;
              mem_addr_valid <= 1'b0;
              state          <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Initiator for the 64-bit CPU-side IO bus (`mem_addr` / `mem_addr_valid` / `mem_dout_write` / `mem_din_ready`). It accepts queued read and write requests from an internal requester, such as a debug port or DMA engine, and drives them onto the bus one at a time. It waits for the responder's ready, with a timeout, and returns one response per request. It sits between the requester and the IO address decoder and peripheral responders (LED, SW, VGA).

## Interface
- `FIFO_DEPTH`, 4: request queue depth; power of 2, minimum 2.
- `TIMEOUT`, 16'd255: maximum BUS-state cycles without ready before the transaction is aborted; minimum 1.
- `clk` in 1: clock; all logic on posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `req_valid` in 1: request offered.
- `req_ready` out 1: queue not full; equals `count != FIFO_DEPTH`.
- `req_write` in 1: 1 means write, 0 means read.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: write data.
- `resp_valid` out 1: response held until accepted.
- `resp_ready` in 1: requester accepts the response.
- `resp_rdata` out 64: read data; 0 for writes and errors.
- `resp_err` out 1: request was misaligned or timed out.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current queue occupancy.
- `busy` out 1: state is not IDLE, or the queue is non-empty.
- `mem_addr` out 64: bus address; 0 whenever `mem_addr_valid` is low.
- `mem_dout` out 64: write data; 0 on reads and when idle.
- `mem_dout_write` out 1: write strobe; qualified by `mem_addr_valid`.
- `mem_addr_valid` out 1: transaction active.
- `mem_din` in 64: read data from the responder.
- `mem_din_ready` in 1: responder completes the transaction at this posedge.

## Operation
- Request FIFO:
  - A push occurs when `req_valid & req_ready` at posedge.
  - A pop occurs only in IDLE when the queue is non-empty.
  - There is no bypass: a request pushed into an empty queue is popped no earlier than the next edge.
  - Push and pop in the same edge are legal; the level is unchanged.
- FSM states are IDLE, BUS and RESP.
- IDLE, queue non-empty:
  - Pop the head entry.
  - If `addr[2:0] != 0`, load `resp_err=1` and `resp_rdata=0`, go to RESP, and issue no bus cycle.
  - Otherwise register addr, wdata and write onto the bus outputs, set `mem_addr_valid=1`, clear the timeout counter, and go to BUS.
- BUS:
  - Bus outputs are held stable.
  - If `mem_din_ready`=1 at the edge: `resp_rdata` = write ? 0 : `mem_din`, `resp_err=0`, drop `mem_addr_valid` and zero `mem_addr`, `mem_dout` and `mem_dout_write`, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT: `resp_err=1`, `resp_rdata=0`, drop the bus outputs, go to RESP.
  - If ready and the timeout coincide at the same edge, ready wins.
- RESP:
  - `resp_valid=1`; `resp_rdata` and `resp_err` are held.
  - On `resp_ready` at posedge: `resp_valid=0`, go to IDLE.
- `mem_din_ready` is ignored outside BUS.
- Responses return in request order, exactly one per accepted request.

## Timing
- Reset values:
  - All bus outputs, `resp_valid`, `resp_rdata`, `resp_err` and `busy` are 0.
  - `fifo_level` is 0 and `req_ready` is 1.
  - State is IDLE and the counter is 0.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately, asynchronously.
  - Queue contents and the in-flight request are discarded; no response is issued.
- Minimum latency, with ready tied to `mem_addr_valid` and `resp_ready`=1:
  - Push at edge N.
  - `mem_addr_valid` high after edge N+1.
  - Complete at N+2; `resp_valid` high after N+2.
  - Back in IDLE at N+3.
- `mem_addr_valid` is low for at least 2 cycles (RESP, IDLE) between consecutive transactions.
- A misaligned request gives `resp_valid` 1 cycle after its pop edge and produces no bus activity.
- Timeout: with ready never asserted, `mem_addr_valid` stays high for exactly TIMEOUT cycles.
- Full queue: `req_ready`=0 while level = FIFO_DEPTH. A pop frees a slot and `req_ready` rises in the same cycle the level drops.

## Test plan
- Write: push write addr 0x1000, data 0xBEEF with ready tied to valid. Required:
  - `mem_addr_valid` high for exactly 1 cycle with `mem_addr`=0x1000, `mem_dout`=0xBEEF, `mem_dout_write`=1.
  - Response has `resp_err`=0 and `resp_rdata`=0.
- Read: push read addr 0x2000; responder drives `mem_din`=0x1234 and ready 3 cycles after valid rises. Required:
  - Bus outputs stable for 4 cycles.
  - `resp_rdata`=0x1234, `resp_err`=0.
- Misaligned: push read addr 0x2004. Required: no `mem_addr_valid` pulse; response with `resp_err`=1 and `resp_rdata`=0.
- Timeout: with TIMEOUT=8 and ready held low, push a read. Required:
  - Valid high for exactly 8 cycles.
  - `resp_err`=1, `resp_rdata`=0.
  - A subsequent request completes normally.
- Queue and backpressure: with `resp_ready`=0, push 5 requests back-to-back (FIFO_DEPTH=4). Required:
  - `req_ready` drops after the queue fills.
  - Releasing `resp_ready` drains all responses in order with correct data.
- Reset mid-BUS: assert `rst_n` low while `mem_addr_valid`=1 and 2 requests are queued. Required:
  - All outputs are 0 immediately and `fifo_level`=0.
  - No response appears after reset release.
